// File: rtl/regfile_wr_sched.sv
// -----------------------------------------------------------------------------
// regfile_wr_sched
//   Write-port scheduler for the 15-entry register file (r0-r14; r15 is the PC
//   and is never written). It merges two writers onto one registered write port.
//     - Writer A: single-cycle pipeline writeback. It always wins the port.
//     - Writer B: 64-bit long-multiply result, written as two 32-bit halves.
//   A pending-write mask lets decode interlock on in-flight B destinations.
//
//   Handshake: B uses valid/ready. A request transfers in a cycle where
//   b_valid && b_ready. b_ready is high only while the scheduler is IDLE, so
//   there is no buffering beyond the one held result.
//
// Ports
//   clk, reset_n             clock, synchronous active-low reset
//   a_we, a_wa, a_wd         writer A enable / address / data
//   b_valid, b_ready         writer B handshake
//   b_wa_lo, b_wa_hi, b_wd   writer B addresses and 64-bit data (lo in low half)
//   rf_we, rf_wa, rf_wd      registered register-file write port
//   pend_mask                bit n set while a B write to rn is outstanding
//   stall_a                  asks upstream to hold a_we low (B starving)
//   wr_err                   one-cycle pulse when a write to r15 is dropped
// -----------------------------------------------------------------------------
module regfile_wr_sched #(
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                a_we,
    input  logic [3:0]          a_wa,
    input  logic [DATA_W-1:0]   a_wd,
    input  logic                b_valid,
    output logic                b_ready,
    input  logic [3:0]          b_wa_lo,
    input  logic [3:0]          b_wa_hi,
    input  logic [2*DATA_W-1:0] b_wd,
    output logic                rf_we,
    output logic [3:0]          rf_wa,
    output logic [DATA_W-1:0]   rf_wd,
    output logic [15:0]         pend_mask,
    output logic                stall_a,
    output logic                wr_err
);

    typedef enum logic [1:0] {IDLE = 2'd0, LO = 2'd1, HI = 2'd2} state_t;

    localparam int              CNT_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT  = CNT_W'(STARVE_LIMIT);
    localparam logic [3:0]      PC_ADDR = 4'd15;

    state_t             state;
    logic [3:0]         lo_wa, hi_wa;
    logic [DATA_W-1:0]  lo_wd, hi_wd;
    logic               lo_todo, hi_todo;
    logic [CNT_W-1:0]   stall_cnt;

    // Decisions for the current cycle, registered by the single always_ff.
    state_t             state_n;
    logic [CNT_W-1:0]   cnt_n;
    logic               half_todo;
    logic               b_blocked;
    logic               b_issue;
    logic [3:0]         b_addr;
    logic [DATA_W-1:0]  b_data;
    logic               a_write;
    logic               accept;
    logic               lo_todo_n, hi_todo_n;
    logic               err_n;

    assign b_ready = (state == IDLE);
    assign accept  = b_valid && (state == IDLE);
    assign a_write = a_we && (a_wa != PC_ADDR);

    always_comb begin
        half_todo = 1'b0;
        b_addr    = lo_wa;
        b_data    = lo_wd;
        if (state == LO) begin
            half_todo = lo_todo;
        end else if (state == HI) begin
            half_todo = hi_todo;
            b_addr    = hi_wa;
            b_data    = hi_wd;
        end
        // Any a_we blocks B, even one to r15 that is then dropped.
        b_blocked = half_todo && a_we;
        b_issue   = half_todo && !a_we;

        state_n = state;
        case (state)
            IDLE:    state_n = b_valid ? LO : IDLE;
            LO:      state_n = b_blocked ? LO : HI;
            HI:      state_n = b_blocked ? HI : IDLE;
            default: state_n = IDLE;
        endcase

        cnt_n = stall_cnt;
        if (state == IDLE || b_issue) begin
            cnt_n = '0;
        end else if (b_blocked && stall_cnt != LIMIT) begin
            cnt_n = stall_cnt + 1'b1;   // saturates at the limit
        end

        // A younger A write to a pending destination cancels that B half.
        if (accept) begin
            lo_todo_n = (b_wa_lo != PC_ADDR);
            hi_todo_n = (b_wa_hi != PC_ADDR);
        end else begin
            lo_todo_n = lo_todo && !(state == LO && b_issue)
                        && !(a_write && a_wa == lo_wa);
            hi_todo_n = hi_todo && !(state == HI && b_issue)
                        && !(a_write && a_wa == hi_wa);
        end

        err_n = (a_we && a_wa == PC_ADDR)
                || (accept && (b_wa_lo == PC_ADDR || b_wa_hi == PC_ADDR));
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            lo_wa     <= '0;
            hi_wa     <= '0;
            lo_wd     <= '0;
            hi_wd     <= '0;
            lo_todo   <= 1'b0;
            hi_todo   <= 1'b0;
            stall_cnt <= '0;
            rf_we     <= 1'b0;
            rf_wa     <= '0;
            rf_wd     <= '0;
            stall_a   <= 1'b0;
            wr_err    <= 1'b0;
        end else begin
            state     <= state_n;
            stall_cnt <= cnt_n;
            lo_todo   <= lo_todo_n;
            hi_todo   <= hi_todo_n;
            stall_a   <= (cnt_n >= LIMIT) && (state_n != IDLE);
            wr_err    <= err_n;
            if (accept) begin
                lo_wa <= b_wa_lo;
                hi_wa <= b_wa_hi;
                lo_wd <= b_wd[DATA_W-1:0];
                hi_wd <= b_wd[2*DATA_W-1:DATA_W];
            end
            // Address/data hold their last values when nothing is written.
            if (a_write) begin
                rf_we <= 1'b1;
                rf_wa <= a_wa;
                rf_wd <= a_wd;
            end else if (b_issue) begin
                rf_we <= 1'b1;
                rf_wa <= b_addr;
                rf_wd <= b_data;
            end else begin
                rf_we <= 1'b0;
            end
        end
    end

    // Derived from the todo bits so a cancelled or written half drops out the
    // same cycle its todo clears; r15 halves never set a todo bit.
    always_comb begin
        pend_mask = '0;
        if (lo_todo) pend_mask[lo_wa] = 1'b1;
        if (hi_todo) pend_mask[hi_wa] = 1'b1;
    end

endmodule

// File: tb/tb_regfile_wr_sched.sv
module tb_regfile_wr_sched;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        a_we;
    logic [3:0]  a_wa;
    logic [31:0] a_wd;
    logic        b_valid;
    logic        b_ready;
    logic [3:0]  b_wa_lo, b_wa_hi;
    logic [63:0] b_wd;
    logic        rf_we;
    logic [3:0]  rf_wa;
    logic [31:0] rf_wd;
    logic [15:0] pend_mask;
    logic        stall_a;
    logic        wr_err;

    int checks   = 0;
    int failures = 0;

    // Expected output events: {is_err, addr, data}.
    logic [36:0] exp_q[$];

    regfile_wr_sched #(.DATA_W(32), .STARVE_LIMIT(2)) dut (
        .clk(clk), .reset_n(reset_n),
        .a_we(a_we), .a_wa(a_wa), .a_wd(a_wd),
        .b_valid(b_valid), .b_ready(b_ready),
        .b_wa_lo(b_wa_lo), .b_wa_hi(b_wa_hi), .b_wd(b_wd),
        .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
        .pend_mask(pend_mask), .stall_a(stall_a), .wr_err(wr_err)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_wr(input logic [3:0] wa, input logic [31:0] wd);
        exp_q.push_back({1'b0, wa, wd});
    endtask

    task automatic push_err();
        exp_q.push_back({1'b1, 4'd0, 32'd0});
    endtask

    // Drives one B request for a single cycle; returns one cycle after accept.
    task automatic b_accept(input logic [3:0] lo, input logic [3:0] hi, input logic [63:0] wd);
        b_valid = 1'b1;
        b_wa_lo = lo;
        b_wa_hi = hi;
        b_wd    = wd;
        check("b_ready_at_accept", 64'(b_ready), 64'd1);
        tick();
        b_valid = 1'b0;
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (rf_we || wr_err) begin
            logic [36:0] act;
            logic [36:0] exp;
            act = rf_we ? {1'b0, rf_wa, rf_wd} : {1'b1, 4'd0, 32'd0};
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_event: got %0h expected none", act);
            end else begin
                exp = exp_q.pop_front();
                if (act !== exp) begin
                    failures++;
                    $display("FAIL sb_event: got %0h expected %0h", act, exp);
                end
            end
        end
    end

    initial begin
        reset_n = 1'b0;
        a_we = 1'b0; a_wa = '0; a_wd = '0;
        b_valid = 1'b0; b_wa_lo = '0; b_wa_hi = '0; b_wd = '0;

        // 1. reset
        tick(); tick();
        check("rst_rf_we", 64'(rf_we), 64'd0);
        check("rst_pend", 64'(pend_mask), 64'd0);
        check("rst_stall", 64'(stall_a), 64'd0);
        check("rst_wr_err", 64'(wr_err), 64'd0);
        reset_n = 1'b1;
        tick();
        check("rel_b_ready", 64'(b_ready), 64'd1);
        check("rel_rf_we", 64'(rf_we), 64'd0);

        // 2. B alone
        push_wr(4'd2, 32'h3333_4444);
        push_wr(4'd3, 32'h1111_2222);
        b_accept(4'd2, 4'd3, 64'h1111_2222_3333_4444);       // now t+1
        check("b2_ready_busy", 64'(b_ready), 64'd0);
        check("b2_pend_t1", 64'(pend_mask), 64'h000C);
        check("b2_rf_we_t1", 64'(rf_we), 64'd0);
        tick();                                               // t+2
        check("b2_lo_we", 64'(rf_we), 64'd1);
        check("b2_pend_t2", 64'(pend_mask), 64'h0008);
        tick();                                               // t+3
        check("b2_hi_we", 64'(rf_we), 64'd1);
        check("b2_pend_t3", 64'(pend_mask), 64'h0000);
        check("b2_ready_t3", 64'(b_ready), 64'd1);
        tick();                                               // t+4
        check("b2_idle_we", 64'(rf_we), 64'd0);
        check("b2_hold_wa", 64'(rf_wa), 64'd3);
        check("b2_hold_wd", 64'(rf_wd), 64'h1111_2222);

        // 3. A blocks B, starvation
        b_accept(4'd4, 4'd6, 64'hAAAA_0006_BBBB_0004);       // t+1
        for (int k = 0; k < 4; k++) begin
            a_we = 1'b1; a_wa = 4'd1; a_wd = 32'h100 + 32'(k);
            push_wr(4'd1, 32'h100 + 32'(k));
            check($sformatf("b3_stall_blk%0d", k + 1), 64'(stall_a), (k >= 2) ? 64'd1 : 64'd0);
            tick();
        end
        a_we = 1'b0;                                          // t+5
        push_wr(4'd4, 32'hBBBB_0004);
        push_wr(4'd6, 32'hAAAA_0006);
        check("b3_stall_t5", 64'(stall_a), 64'd1);
        check("b3_pend_t5", 64'(pend_mask), 64'h0050);
        tick();                                               // t+6
        check("b3_stall_t6", 64'(stall_a), 64'd0);
        check("b3_lo_wa", 64'(rf_wa), 64'd4);
        tick();                                               // t+7
        check("b3_hi_wa", 64'(rf_wa), 64'd6);
        tick();

        // 4. WAW cancel of lo half
        b_accept(4'd5, 4'd7, 64'h7777_7777_5555_5555);       // t+1
        a_we = 1'b1; a_wa = 4'd5; a_wd = 32'hDEAD;
        push_wr(4'd5, 32'hDEAD);
        check("b4_pend_t1", 64'(pend_mask), 64'h00A0);
        tick();                                               // t+2
        a_we = 1'b0;
        check("b4_pend_cancel", 64'(pend_mask), 64'h0080);
        check("b4_a_wd", 64'(rf_wd), 64'hDEAD);
        tick();                                               // t+3
        push_wr(4'd7, 32'h7777_7777);
        check("b4_no_lo_write", 64'(rf_we), 64'd0);
        tick();                                               // t+4
        check("b4_hi_we", 64'(rf_we), 64'd1);
        check("b4_pend_done", 64'(pend_mask), 64'h0000);
        tick();

        // 5. r15 handling
        a_we = 1'b1; a_wa = 4'd15; a_wd = 32'hBAD0;
        push_err();
        tick();
        a_we = 1'b0;
        check("b5_a15_we", 64'(rf_we), 64'd0);
        check("b5_a15_err", 64'(wr_err), 64'd1);
        tick();
        check("b5_err_pulse", 64'(wr_err), 64'd0);
        push_err();
        push_wr(4'd8, 32'h0000_8888);
        b_accept(4'd8, 4'd15, 64'hFFFF_FFFF_0000_8888);      // t+1
        check("b5_pend_t1", 64'(pend_mask), 64'h0100);
        tick();                                               // t+2
        check("b5_lo_wa", 64'(rf_wa), 64'd8);
        tick();                                               // t+3
        check("b5_no_hi", 64'(rf_we), 64'd0);
        check("b5_ready_t3", 64'(b_ready), 64'd1);

        // 6. reset while in HI
        push_wr(4'd9, 32'h5555_0909);
        b_accept(4'd9, 4'd10, 64'hAAAA_1010_5555_0909);      // t+1
        tick();                                               // t+2, HI
        check("b6_pend_hi", 64'(pend_mask), 64'h0400);
        reset_n = 1'b0;
        tick();
        check("b6_rst_we", 64'(rf_we), 64'd0);
        check("b6_rst_pend", 64'(pend_mask), 64'd0);
        check("b6_rst_ready", 64'(b_ready), 64'd1);
        reset_n = 1'b1;
        tick();
        check("b6_rel_we", 64'(rf_we), 64'd0);
        check("b6_rel_ready", 64'(b_ready), 64'd1);
        check("b6_rel_wa", 64'(rf_wa), 64'd0);

        // drain, bounded
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
        tick();
        check("sb_drained", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
